// File: rtl/park_exit.sv
// park_exit: exit-lane controller for the parking lot.
// Validates the exit code, opens the gate, confirms the car has passed, and
// keeps the lot occupancy (raised by the entrance side, lowered here).
//
// state       | meaning
// ------------|-------------------------------------------------------------
// S_IDLE      | lane empty, or lot empty so nobody can be leaving
// S_WAIT_CODE | car at the lane, settling time before sampling the code
// S_BAD_CODE  | sampled code was wrong, waiting for a good code or departure
// S_OPEN      | gate open, waiting (bounded) for the car to reach the gate
// S_CLEAR     | car under the gate, occupancy drops when it has passed
module park_exit #(
  parameter int unsigned WAIT_CYCLES  = 10,
  parameter int unsigned OPEN_TIMEOUT = 20,
  parameter int unsigned CAPACITY     = 8,
  parameter logic [1:0]  CODE_1       = 2'b10,
  parameter logic [1:0]  CODE_2       = 2'b01
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sensor_exit,
  input  logic                            sensor_gate,
  input  logic [1:0]                      exit_code_1,
  input  logic [1:0]                      exit_code_2,
  input  logic                            car_entered,
  output logic                            GREEN_LED,
  output logic                            RED_LED,
  output logic [6:0]                      HEX_1,
  output logic [6:0]                      HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
  output logic                            lot_full
);

  localparam int unsigned OCC_W  = $clog2(CAPACITY + 1);
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned OCNT_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYCLES);
  localparam logic [OCNT_W-1:0] OPEN_LAST = OCNT_W'(OPEN_TIMEOUT - 1);
  localparam logic [OCC_W-1:0]  OCC_MAX   = OCC_W'(CAPACITY);

  // Active-low segment patterns, gfedcba
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_H   = 7'b0001001;
  localparam logic [6:0] SEG_G   = 7'b0000010;
  localparam logic [6:0] SEG_O   = 7'b1000000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CODE = 3'd1,
    S_BAD_CODE  = 3'd2,
    S_OPEN      = 3'd3,
    S_CLEAR     = 3'd4
  } state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic [OCNT_W-1:0]   open_cnt_q;
  logic                green_q;
  logic                red_q;
  logic [6:0]          hex1_q;
  logic [6:0]          hex2_q;
  logic [OCC_W-1:0]    occ_q;
  logic [OCC_W-1:0]    occ_d;

  logic code_ok;
  logic car_left;

  assign code_ok  = (exit_code_1 == CODE_1) && (exit_code_2 == CODE_2);
  // The CLEAR->IDLE edge is the only event that removes a car from the lot
  assign car_left = (state_q == S_CLEAR) && !sensor_gate;

  // Occupancy next value: simultaneous arrival and departure cancel out
  always_comb begin
    occ_d = occ_q;
    if (car_entered && car_left) begin
      occ_d = occ_q;
    end else if (car_entered && (occ_q != OCC_MAX)) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (car_left && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Exit FSM: state, phase counters and lane outputs registered from current state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      open_cnt_q <= '0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
      hex1_q     <= SEG_OFF;
      hex2_q     <= SEG_OFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          green_q <= 1'b0;
          red_q   <= 1'b0;
          hex1_q  <= SEG_OFF;
          hex2_q  <= SEG_OFF;
          if (sensor_exit && (occ_q != '0)) begin
            state_q    <= S_WAIT_CODE;
            wait_cnt_q <= '0;
          end
        end
        S_WAIT_CODE: begin
          green_q <= 1'b0;
          red_q   <= 1'b1;
          hex1_q  <= SEG_E;
          hex2_q  <= SEG_H;
          if (wait_cnt_q == WAIT_LAST) begin
            if (code_ok) begin
              state_q    <= S_OPEN;
              open_cnt_q <= '0;
            end else begin
              state_q <= S_BAD_CODE;
            end
          end else if (!sensor_exit) begin
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
        end
        S_BAD_CODE: begin
          green_q <= 1'b0;
          red_q   <= ~red_q;
          hex1_q  <= SEG_E;
          hex2_q  <= SEG_E;
          if (code_ok) begin
            state_q    <= S_OPEN;
            open_cnt_q <= '0;
          end else if (!sensor_exit) begin
            state_q <= S_IDLE;
          end
        end
        S_OPEN: begin
          green_q <= 1'b1;
          red_q   <= 1'b0;
          hex1_q  <= SEG_G;
          hex2_q  <= SEG_O;
          if (sensor_gate) begin
            state_q <= S_CLEAR;
          end else if (open_cnt_q == OPEN_LAST) begin
            state_q <= S_IDLE;
          end else begin
            open_cnt_q <= open_cnt_q + OCNT_W'(1);
          end
        end
        S_CLEAR: begin
          green_q <= ~green_q;
          red_q   <= 1'b0;
          hex1_q  <= SEG_G;
          hex2_q  <= SEG_O;
          if (!sensor_gate) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          green_q <= 1'b0;
          red_q   <= 1'b0;
          hex1_q  <= SEG_OFF;
          hex2_q  <= SEG_OFF;
        end
      endcase
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;
  assign occupancy = occ_q;
  assign lot_full  = (occ_q == OCC_MAX);

endmodule
